zbb_bit_counter: RTL and testbench

Iterative Zbb count unit for the execute stage, the inverse of the barrel shifter: the shifter takes a distance and moves bits; this unit takes bits and returns a distance. It computes CLZ, CTZ and CPOP, including the W forms CLZW, CTZW and CPOPW. It scans the operand CHUNK bits per cycle, with early termination for CLZ/CTZ. It uses valid/ready handshakes on both sides and sits beside the ALU as a multi-cycle functional unit.

---
 rtl/zbb_bit_counter.sv | 138 +++++++++++++
 tb/tb_zbb_bit_counter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/zbb_bit_counter.sv
// Iterative Zbb count unit: CLZ/CTZ/CPOP (and W forms), CHUNK bits per cycle, MSB-first scan.
// Optional CPOP datapath is enabled by defining ZBB_CPOP_EN.
module zbb_bit_counter #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] operand,
    input  logic [1:0]       count_op,
    input  logic             is_32_bit_mode,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result
);
    localparam int HALF    = WIDTH / 2;
    localparam int CNT_W   = $clog2(WIDTH) + 1;
    localparam int NC_FULL = WIDTH / CHUNK;
    localparam int NC_HALF = HALF / CHUNK;
    localparam int IDX_W   = $clog2(NC_FULL) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   scan_reg, scan_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [IDX_W-1:0]   chunk_idx_reg, chunk_idx_next;
    logic               cpop_reg, cpop_next;
    logic               w_reg, w_next;

    logic [WIDTH-1:0]   operand_rev;
    logic [WIDTH-1:0]   scan_load;
    logic [CHUNK-1:0]   chunk;
    logic [CNT_W-1:0]   chunk_lz;
    logic               last_chunk;
    logic               is_ctz;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign operand_rev[gi] = operand[WIDTH-1-gi];
        end
    endgenerate

    // The top half of the full reversal is exactly the reversed low half, which CTZW needs.
    assign is_ctz    = (count_op == 2'b01);
    assign scan_load = is_32_bit_mode
                     ? {(is_ctz ? operand_rev[WIDTH-1 -: HALF] : operand[HALF-1:0]), {HALF{1'b0}}}
                     : (is_ctz ? operand_rev : operand);

    assign chunk      = scan_reg[WIDTH-1 -: CHUNK];
    assign last_chunk = (chunk_idx_reg == (w_reg ? IDX_W'(NC_HALF - 1) : IDX_W'(NC_FULL - 1)));

    // Leading zeros of the current chunk; an all-zero chunk counts as CHUNK.
    always_comb begin
        chunk_lz = CNT_W'(CHUNK);
        for (int i = 0; i < CHUNK; i++) begin
            if (chunk[i]) chunk_lz = CNT_W'(CHUNK - 1 - i);
        end
    end

`ifdef ZBB_CPOP_EN
    logic [CNT_W-1:0] chunk_pop;
    always_comb begin
        chunk_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_pop = chunk_pop + CNT_W'(chunk[i]);
        end
    end
`endif

    always_comb begin
        state_next     = state_reg;
        scan_next      = scan_reg;
        cnt_next       = cnt_reg;
        chunk_idx_next = chunk_idx_reg;
        cpop_next      = cpop_reg;
        w_next         = w_reg;
        case (state_reg)
            IDLE: begin
                if (start_valid && !flush) begin
                    scan_next      = scan_load;
                    cnt_next       = '0;
                    chunk_idx_next = '0;
                    cpop_next      = (count_op == 2'b10);
                    w_next         = is_32_bit_mode;
                    state_next     = BUSY;
                end
            end
            BUSY: begin
                scan_next      = scan_reg << CHUNK;
                chunk_idx_next = chunk_idx_reg + 1'b1;
                if (cpop_reg) begin
`ifdef ZBB_CPOP_EN
                    cnt_next = cnt_reg + chunk_pop;
                    if (last_chunk) state_next = DONE;
`else
                    state_next = DONE;
`endif
                end else begin
                    cnt_next = cnt_reg + chunk_lz;
                    if (chunk != '0 || last_chunk) state_next = DONE;
                end
            end
            DONE: begin
                if (result_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            scan_reg      <= '0;
            cnt_reg       <= '0;
            chunk_idx_reg <= '0;
            cpop_reg      <= 1'b0;
            w_reg         <= 1'b0;
        end else begin
            state_reg     <= state_next;
            scan_reg      <= scan_next;
            cnt_reg       <= cnt_next;
            chunk_idx_reg <= chunk_idx_next;
            cpop_reg      <= cpop_next;
            w_reg         <= w_next;
        end
    end

    assign start_ready  = (state_reg == IDLE);
    assign result_valid = (state_reg == DONE);
    assign result       = {{(WIDTH - CNT_W){1'b0}}, cnt_reg};

endmodule

// File: tb/tb_zbb_bit_counter.sv
// Directed-vector bench for zbb_bit_counter: results, latencies, backpressure, flush and reset.
module tb_zbb_bit_counter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        start_valid;
    logic        start_ready;
    logic [63:0] operand;
    logic [1:0]  count_op;
    logic        is_32_bit_mode;
    logic        result_valid;
    logic        result_ready;
    logic [63:0] result;

    int n_pass  = 0;
    int n_total = 0;

    zbb_bit_counter #(.WIDTH(64), .CHUNK(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .start_valid    (start_valid),
        .start_ready    (start_ready),
        .operand        (operand),
        .count_op       (count_op),
        .is_32_bit_mode (is_32_bit_mode),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result         (result)
    );

    always #5 clk = ~clk;

    // Stimulus only: issue one request, wait (bounded) for result_valid, report what was seen.
    task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] opnd,
                          output logic [63:0] res, output int lat, output logic rv);
        start_valid    = 1'b1;
        count_op       = op;
        is_32_bit_mode = w;
        operand        = opnd;
        @(posedge clk); #1;
        start_valid = 1'b0;
        lat = 0;
        while (!result_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        rv  = result_valid;
        res = result;
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
        operand = '0; count_op = 2'b00; is_32_bit_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (start_ready !== 1'b1) $display("FAIL reset_start_ready got=%b want=1", start_ready);
        else n_pass++;
        n_total++;
        if (result_valid !== 1'b0) $display("FAIL reset_result_valid got=%b want=0", result_valid);
        else n_pass++;
        n_total++;
        if (result !== 64'd0) $display("FAIL reset_result got=%0d want=0", result);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One directed vector: result value, latency in edges after accept, and return to idle.
    task automatic test_vector(input string name, input logic [1:0] op, input logic w,
                               input logic [63:0] opnd, input logic [63:0] exp_res, input int exp_lat);
        logic [63:0] res;
        int          lat;
        logic        rv;
        run_op(op, w, opnd, res, lat, rv);
        n_total++;
        if (rv !== 1'b1) $display("FAIL %s_valid_timeout got=%b want=1", name, rv);
        else n_pass++;
        n_total++;
        if (res !== exp_res) $display("FAIL %s_result got=%0d want=%0d", name, res, exp_res);
        else n_pass++;
        n_total++;
        if (lat != exp_lat) $display("FAIL %s_latency got=T+%0d want=T+%0d", name, lat, exp_lat);
        else n_pass++;
        release_result();
        n_total++;
        if (start_ready !== 1'b1 || result_valid !== 1'b0)
            $display("FAIL %s_return_idle got ready=%b valid=%b want ready=1 valid=0",
                     name, start_ready, result_valid);
        else n_pass++;
        $display("%s: result=%0d latency=T+%0d", name, res, lat);
    endtask

    task automatic test_backpressure();
        logic [63:0] res;
        int          lat;
        logic        rv;
        run_op(2'b00, 1'b0, 64'h0000_0100_0000_0000, res, lat, rv);
        n_total++;
        if (rv !== 1'b1 || res !== 64'd23 || lat != 3)
            $display("FAIL bp_first got valid=%b result=%0d lat=%0d want valid=1 result=23 lat=3",
                     rv, res, lat);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (result_valid !== 1'b1 || result !== 64'd23 || start_ready !== 1'b0)
                $display("FAIL bp_hold%0d got valid=%b result=%0d ready=%b want valid=1 result=23 ready=0",
                         i, result_valid, result, start_ready);
            else n_pass++;
        end
        release_result();
        n_total++;
        if (start_ready !== 1'b1) $display("FAIL bp_release_ready got=%b want=1", start_ready);
        else n_pass++;
        $display("backpressure: held result=%0d for 5 cycles", res);
    endtask

    task automatic test_flush();
        logic [1:0]  op;
        logic [63:0] opnd;
`ifdef ZBB_CPOP_EN
        op = 2'b10; opnd = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        op = 2'b00; opnd = 64'd0;
`endif
        start_valid = 1'b1; count_op = op; is_32_bit_mode = 1'b0; operand = opnd;
        @(posedge clk); #1;           // accept edge T
        start_valid = 1'b0;
        @(posedge clk); #1;           // T+1
        @(posedge clk); #1;           // T+2
        flush = 1'b1; start_valid = 1'b1;
        @(posedge clk); #1;           // T+3: flush takes effect
        n_total++;
        if (result_valid !== 1'b0 || start_ready !== 1'b1)
            $display("FAIL flush_idle got valid=%b ready=%b want valid=0 ready=1", result_valid, start_ready);
        else n_pass++;
        @(posedge clk); #1;           // start_valid with flush in IDLE must be ignored
        n_total++;
        if (start_ready !== 1'b1) $display("FAIL flush_blocks_start got ready=%b want=1", start_ready);
        else n_pass++;
        flush = 1'b0; start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (result_valid !== 1'b0) $display("FAIL flush_no_result got=%b want=0", result_valid);
        else n_pass++;
        $display("flush: unit idle, no result produced");
    endtask

    task automatic test_reset_busy();
        start_valid = 1'b1; count_op = 2'b00; is_32_bit_mode = 1'b0; operand = 64'd0;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (result_valid !== 1'b0 || start_ready !== 1'b1 || result !== 64'd0)
            $display("FAIL reset_busy got valid=%b ready=%b result=%0d want valid=0 ready=1 result=0",
                     result_valid, start_ready, result);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset_busy: unit back in idle");
    endtask

    initial begin
        test_reset();
        test_vector("clz_bit16",   2'b00, 1'b0, 64'h0000_0000_0001_0000, 64'd47, 6);
        test_vector("ctzw_upper",  2'b01, 1'b1, 64'hFFFF_FFFF_0000_0100, 64'd8,  2);
        test_vector("clz_zero",    2'b00, 1'b0, 64'd0,                   64'd64, 8);
        test_vector("clzw_zero",   2'b00, 1'b1, 64'd0,                   64'd32, 4);
        test_vector("ctz_msb",     2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 8);
        test_vector("ctzw_zero",   2'b01, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'd32, 4);
        test_vector("rsvd_as_clz", 2'b11, 1'b0, 64'h0000_0000_0001_0000, 64'd47, 6);
`ifdef ZBB_CPOP_EN
        test_vector("cpop",        2'b10, 1'b0, 64'hF0F0_0000_0000_0001, 64'd9,  8);
        test_vector("cpopw",       2'b10, 1'b1, 64'hFFFF_FFFF_8000_0003, 64'd3,  4);
`else
        test_vector("cpop_off",    2'b10, 1'b0, 64'hF0F0_0000_0000_0001, 64'd0,  1);
        test_vector("cpopw_off",   2'b10, 1'b1, 64'hFFFF_FFFF_8000_0003, 64'd0,  1);
`endif
        test_backpressure();
        test_flush();
        test_vector("clz_after_flush", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 1);
        test_reset_busy();
        test_vector("clz_after_reset", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
